wb_queue: RTL

//  Write-back side of the CPU register file: merges single-cycle ALU results and

---
 rtl/wb_queue_if.sv | 39 +++
 rtl/wb_queue.sv | 120 ++++++++++++
 2 files changed

// File: rtl/wb_queue_if.sv
// Write-back queue bus: ALU/slow-unit results in, regfile write port and
// scoreboard status out. master = pipeline side, slave = wb_queue.
interface wb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_we;
    logic [4:0]        alu_wn;
    logic [DATA_W-1:0] alu_d;
    logic              slow_valid;
    logic [4:0]        slow_wn;
    logic [DATA_W-1:0] slow_d;
    logic              slow_ready;
    logic              iss_valid;
    logic [4:0]        iss_wn;
    logic [4:0]        rna;
    logic [4:0]        rnb;
    logic              busy_a;
    logic              busy_b;
    logic              stall_req;
    logic              wb_we;
    logic [4:0]        wb_wn;
    logic [DATA_W-1:0] wb_d;
    logic [CNT_W-1:0]  fifo_cnt;

    modport master (
        output alu_we, alu_wn, alu_d, slow_valid, slow_wn, slow_d,
               iss_valid, iss_wn, rna, rnb,
        input  slow_ready, busy_a, busy_b, stall_req, wb_we, wb_wn, wb_d, fifo_cnt
    );

    modport slave (
        input  alu_we, alu_wn, alu_d, slow_valid, slow_wn, slow_d,
               iss_valid, iss_wn, rna, rnb,
        output slow_ready, busy_a, busy_b, stall_req, wb_we, wb_wn, wb_d, fifo_cnt
    );
endinterface

// File: rtl/wb_queue.sv
// Register-file write-back merger: ALU results win the port, slow results queue in
// an in-order FIFO, 32-bit pending scoreboard. Define WBQ_BYPASS_EN for empty-FIFO bypass.
module wb_queue #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic      clk,
    input  logic      clrn,
    wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_W'(STARVE_LIMIT)) ? v : v + 1'b1;
    endfunction

    logic [4:0]        fifo_wn [DEPTH];
    logic [DATA_W-1:0] fifo_d  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       pending, pending_nxt;
    logic [SC_W-1:0]   starve, starve_nxt;

    logic              vld_p1;
    logic [4:0]        wn_p1;
    logic [DATA_W-1:0] d_p1;
    logic              stall_p1;

    logic              alu_sel, empty, full, pop, push, byp, clr_en;
    logic [4:0]        clr_wn, head_wn;
    logic [DATA_W-1:0] head_d;

    assign head_wn = fifo_wn[rd_ptr];
    assign head_d  = fifo_d[rd_ptr];

    always_comb begin
        alu_sel = bus.alu_we && (bus.alu_wn != 5'd0);
        empty   = (cnt == '0);
        full    = (cnt == CNT_W'(DEPTH));
        pop     = !empty && !alu_sel;
`ifdef WBQ_BYPASS_EN
        byp     = bus.slow_valid && empty && !alu_sel;
`else
        byp     = 1'b0;
`endif
        push    = bus.slow_valid && !full && !byp;
        clr_en  = pop || byp;
        clr_wn  = pop ? head_wn : bus.slow_wn;

        // Clear first so a same-edge issue to the same register stays pending.
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_wn] = 1'b0;
        if (bus.iss_valid)
            pending_nxt[bus.iss_wn] = 1'b1;
        pending_nxt[0] = 1'b0;

        starve_nxt = (empty || pop) ? '0 : sat_inc(starve);
    end

    // Stage p1: write-port register, FIFO control, scoreboard, starvation
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_p1   <= 1'b0;
            wn_p1    <= '0;
            d_p1     <= '0;
            stall_p1 <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            pending  <= '0;
            starve   <= '0;
        end else begin
            if (alu_sel) begin
                vld_p1 <= 1'b1;
                wn_p1  <= bus.alu_wn;
                d_p1   <= bus.alu_d;
            end else if (pop) begin
                vld_p1 <= (head_wn != 5'd0);
                wn_p1  <= head_wn;
                d_p1   <= head_d;
            end else if (byp) begin
                vld_p1 <= (bus.slow_wn != 5'd0);
                wn_p1  <= bus.slow_wn;
                d_p1   <= bus.slow_d;
            end else begin
                vld_p1 <= 1'b0;
            end

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt      <= cnt + CNT_W'(push) - CNT_W'(pop);
            pending  <= pending_nxt;
            starve   <= starve_nxt;
            stall_p1 <= (starve_nxt == SC_W'(STARVE_LIMIT));
        end
    end

    // FIFO payload storage carries no reset; occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wn[wr_ptr] <= bus.slow_wn;
            fifo_d[wr_ptr]  <= bus.slow_d;
        end
    end

    assign bus.slow_ready = !full;
    assign bus.busy_a     = (bus.rna != 5'd0) && pending[bus.rna];
    assign bus.busy_b     = (bus.rnb != 5'd0) && pending[bus.rnb];
    assign bus.stall_req  = stall_p1;
    assign bus.wb_we      = vld_p1;
    assign bus.wb_wn      = wn_p1;
    assign bus.wb_d       = d_p1;
    assign bus.fifo_cnt   = cnt;
endmodule
